div_restoring_16: RTL and testbench

//   Iterative unsigned restoring divider. It is the inverse-operation companion
//   to the 16-bit lookahead adder in the datapath, and produces quotient and

---
 rtl/div_restoring_16.sv | 159 +++++++++++++++
 tb/tb_div_restoring_16.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_restoring_16.sv
// Iterative unsigned restoring divider.
// One quotient bit is resolved per clock by a trial subtraction of the divisor
// from the partial remainder. Operands are taken on a valid/ready input
// handshake. The result is held on a valid/ready output handshake until the
// consumer takes it.
module div_restoring_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers: Q shifts out dividend bits and shifts in quotient bits.
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  // Result registers, kept separate so the result survives the next accept.
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic             accept;
  logic             release_res;
  logic             last_step;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             step_ok;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;
  assign last_step   = (state == CALC) && (cnt == '0);

  // One restoring step: trial-subtract the divisor, keep the difference if it
  // did not borrow.
  always_comb begin
    shifted = {r_reg, q_reg[WIDTH-1]};
    trial   = shifted - {1'b0, d_reg};
    step_ok = ~trial[WIDTH];
    r_step  = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_step  = {q_reg[WIDTH-2:0], step_ok};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      CALC:    ;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Working datapath: load on accept, then iterate while in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      cnt   <= CW'(WIDTH - 1);
    end else if (state == CALC) begin
      q_reg <= q_step;
      r_reg <= r_step;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Result registers: written when a division completes, otherwise held.
  // Divide by zero completes at the accept edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept && (divisor == '0)) begin
      quotient_reg  <= '1;
      remainder_reg <= dividend;
      dbz_reg       <= 1'b1;
    end else if (last_step) begin
      quotient_reg  <= q_step;
      remainder_reg <= r_step;
      dbz_reg       <= 1'b0;
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

  // release_res is kept as a named term for readability of the handshake.
  logic unused_ok;
  assign unused_ok = release_res;

endmodule

// File: tb/tb_div_restoring_16.sv
// Scoreboard bench for div_restoring_16: the driver pushes hand-computed
// results at accept, the monitor pops and compares on each output handshake.
module tb_div_restoring_16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  bit   presented = 0;

  div_restoring_16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency checked on first presentation, values on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      presented = 0;
    end else if (out_valid) begin
      if (!presented) begin
        presented = 1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got q=%0h r=%0h with empty scoreboard", quotient, remainder);
        end else begin
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (out_ready) begin
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
        end
        presented = 0;
      end
    end
  end

  // Latency counted in edges after the accept edge: WIDTH steps, or none for divide by zero.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic [15:0] er, input logic edbz);
    int n;
    exp_t e;
    n = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 16'hDEAD;
      divisor  = 16'hBEEF;
      e.q   = eq;
      e.r   = er;
      e.dbz = edbz;
      e.acc = cyc;
      e.lat = (b == 16'd0) ? 0 : 16;
      sb.push_back(e);
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function, back to back.
    send(16'd100,   16'd7,      16'd14,    16'd2,      1'b0);
    send(16'hFFFF,  16'h0001,   16'hFFFF,  16'h0000,   1'b0);
    send(16'hFFFF,  16'hFFFF,   16'h0001,  16'h0000,   1'b0);
    send(16'h8000,  16'h0003,   16'h2AAA,  16'h0002,   1'b0);
    send(16'd5,     16'd9,      16'd0,     16'd5,      1'b0);
    send(16'h0000,  16'h1234,   16'h0000,  16'h0000,   1'b0);
    send(16'h1234,  16'h0000,   16'hFFFF,  16'h1234,   1'b1);
    send(16'h0000,  16'h0000,   16'hFFFF,  16'h0000,   1'b1);
    send(16'd100,   16'd7,      16'd14,    16'd2,      1'b0);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, 16'd333);
      chk("bp_remainder", remainder, 16'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Input activity while busy is ignored.
    send(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      chk("busy_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    chk("hold_after_done", quotient, 16'd406);

    // Reset partway through a division abandons it.
    send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
